// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int BE_W         = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arbState_t;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: counts busy cycles without a memory ack, flags the abort
// cycle and keeps a sticky error until reset.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_busy,
  input  logic i_memAck,
  output logic o_timeout,
  output logic o_err
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wdog;
  logic          r_err;

  // An ack on the limit cycle wins over the abort.
  assign o_timeout = i_busy & ~i_memAck & (r_wdog == WW'(TIMEOUT));
  assign o_err     = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (i_clear) begin
        r_wdog <= '0;
      end else if (i_busy & ~i_memAck & ~o_timeout) begin
        r_wdog <= r_wdog + WW'(1);
      end
      if (o_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch (I) and memory-stage (D)
// requesters with data-first priority and a fetch starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            i_stall,
  output logic            d_stall,
  output logic            timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arbState_t       r_state;
  logic [SW-1:0]   r_streak;
  logic            r_memReq;
  logic            r_memWe;
  logic [BE_W-1:0] r_memBe;
  logic [XLEN-1:0] r_memAddr;
  logic [XLEN-1:0] r_memWdata;

  logic w_busyI, w_busyD, w_busy, w_arbEn;
  logic w_iCand, w_dCand, w_starved, w_grantI, w_grantD;
  logic w_timeout, w_done;

  assign w_busyI = (r_state == ARB_BUSY_I);
  assign w_busyD = (r_state == ARB_BUSY_D);
  assign w_busy  = w_busyI | w_busyD;
  assign w_done  = w_busy & (mem_ack | w_timeout);

  // The side being acked this cycle still holds its req, so it must not re-win.
  assign w_arbEn   = (r_state == ARB_IDLE) | (w_busy & mem_ack);
  assign w_iCand   = i_req & ~w_busyI;
  assign w_dCand   = d_req & ~w_busyD;
  assign w_starved = (r_streak == SW'(STARVE_LIMIT));
  assign w_grantI  = w_arbEn & w_iCand & (~w_dCand | w_starved);
  assign w_grantD  = w_arbEn & w_dCand & ~w_grantI;

  assign i_ack   = rst & w_busyI & (mem_ack | w_timeout);
  assign d_ack   = rst & w_busyD & (mem_ack | w_timeout);
  assign i_rdata = (rst & w_busyI & mem_ack) ? mem_rdata : '0;
  assign d_rdata = (rst & w_busyD & mem_ack) ? mem_rdata : '0;
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_be    = r_memBe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_grantI | w_grantD),
    .i_busy   (w_busy),
    .i_memAck (mem_ack),
    .o_timeout(w_timeout),
    .o_err    (timeout_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_streak   <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memBe    <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      if (w_grantI) begin
        r_state    <= ARB_BUSY_I;
        r_memReq   <= 1'b1;
        r_memWe    <= 1'b0;
        r_memBe    <= '1;
        r_memAddr  <= i_addr;
        r_memWdata <= '0;
      end else if (w_grantD) begin
        r_state    <= ARB_BUSY_D;
        r_memReq   <= 1'b1;
        r_memWe    <= d_we;
        r_memBe    <= d_be;
        r_memAddr  <= d_addr;
        r_memWdata <= d_wdata;
      end else if (w_done) begin
        r_state  <= ARB_IDLE;
        r_memReq <= 1'b0;
      end

      // Streak counts data grants that left a fetch waiting.
      if (w_grantI) begin
        r_streak <= '0;
      end else if (w_grantD & i_req & ~w_starved) begin
        r_streak <= r_streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, withdrawal,
// starvation via repeated timeouts, and reset during an access.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        i_stall;
  logic        d_stall;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int waitCycles;

  mem_port_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(4),
    .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ack      (i_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .i_stall    (i_stall),
    .d_stall    (d_stall),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic memAck, input logic [31:0] memRdata);
    i_req     = iReq;
    i_addr    = iAddr;
    d_req     = dReq;
    d_we      = dWe;
    d_addr    = dAddr;
    d_wdata   = dWdata;
    mem_ack   = memAck;
    mem_rdata = memRdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    rst  = 1'b0;
    d_be = 4'hF;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    clockEdge();
    clockEdge();
    rst = 1'b1;
    #1;
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_be", mem_be, 0);
    checkOutput("reset_i_ack", i_ack, 0);
    checkOutput("reset_d_ack", d_ack, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);

    // Single fetch, memory answers on the third busy cycle.
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("fetch_stall_before", i_stall, 1);
    checkOutput("fetch_req_before", mem_req, 0);
    clockEdge();
    checkOutput("fetch_mem_req", mem_req, 1);
    checkOutput("fetch_mem_addr", mem_addr, 32'h100);
    checkOutput("fetch_mem_we", mem_we, 0);
    checkOutput("fetch_mem_be", mem_be, 4'hF);
    clockEdge();
    clockEdge();
    checkOutput("fetch_no_early_ack", i_ack, 0);
    checkOutput("fetch_hold_addr", mem_addr, 32'h100);
    applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 1, 32'h00500093);
    checkOutput("fetch_i_ack", i_ack, 1);
    checkOutput("fetch_i_rdata", i_rdata, 32'h00500093);
    checkOutput("fetch_stall_at_ack", i_stall, 0);
    clockEdge();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("fetch_idle_req", mem_req, 0);
    checkOutput("fetch_ack_pulse", i_ack, 0);
    checkOutput("fetch_rdata_zero", i_rdata, 0);

    // Simultaneous requests: data first, fetch back-to-back.
    applyStimulus(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 32'h0);
    clockEdge();
    checkOutput("both_d_we", mem_we, 1);
    checkOutput("both_d_be", mem_be, 4'hF);
    checkOutput("both_d_addr", mem_addr, 32'h2000);
    checkOutput("both_d_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("both_i_stall", i_stall, 1);
    applyStimulus(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 1, 32'h0);
    checkOutput("both_d_ack", d_ack, 1);
    checkOutput("both_no_i_ack", i_ack, 0);
    checkOutput("both_d_stall_at_ack", d_stall, 0);
    clockEdge();
    applyStimulus(1, 32'h104, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("both_b2b_req", mem_req, 1);
    checkOutput("both_b2b_we", mem_we, 0);
    checkOutput("both_b2b_addr", mem_addr, 32'h104);
    applyStimulus(1, 32'h104, 0, 0, 32'h0, 32'h0, 1, 32'h00000013);
    checkOutput("both_i_ack", i_ack, 1);
    checkOutput("both_i_rdata", i_rdata, 32'h00000013);
    checkOutput("both_d_rdata_zero", d_rdata, 0);
    clockEdge();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("both_idle_req", mem_req, 0);

    // Fetch withdraws its request mid-access; the ack still arrives.
    applyStimulus(1, 32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    clockEdge();
    applyStimulus(0, 32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("wd_stall_low", i_stall, 0);
    checkOutput("wd_req_kept", mem_req, 1);
    clockEdge();
    checkOutput("wd_addr_held", mem_addr, 32'h200);
    applyStimulus(0, 32'h200, 0, 0, 32'h0, 32'h0, 1, 32'h0000CAFE);
    checkOutput("wd_i_ack", i_ack, 1);
    checkOutput("wd_i_rdata", i_rdata, 32'h0000CAFE);
    clockEdge();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("wd_idle_req", mem_req, 0);

    // Four stores that time out while a fetch waits, then the fetch is forced.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h400, 1, 1, 32'h3000 + 32'(4 * k), 32'h1000 + 32'(k), 0, 32'h0);
      clockEdge();
      checkOutput("starve_d_we", mem_we, 1);
      checkOutput("starve_d_addr", mem_addr, 32'h3000 + 32'(4 * k));
      waitCycles = 0;
      while (d_ack !== 1'b1 && waitCycles < 300) begin
        clockEdge();
        waitCycles++;
      end
      checkOutput("to_wait_cycles", waitCycles, 255);
      checkOutput("to_d_rdata", d_rdata, 0);
      checkOutput("to_i_ack_low", i_ack, 0);
      clockEdge();
      checkOutput("to_mem_req", mem_req, 0);
      checkOutput("to_err_set", timeout_err, 1);
      checkOutput("to_i_stall", i_stall, 1);
    end
    applyStimulus(1, 32'h400, 1, 1, 32'h3010, 32'h1004, 0, 32'h0);
    clockEdge();
    checkOutput("starve_i_forced_we", mem_we, 0);
    checkOutput("starve_i_forced_addr", mem_addr, 32'h400);
    applyStimulus(1, 32'h400, 1, 1, 32'h3010, 32'h1004, 1, 32'h00000777);
    checkOutput("starve_i_ack", i_ack, 1);
    checkOutput("starve_i_rdata", i_rdata, 32'h00000777);
    checkOutput("starve_no_d_ack", d_ack, 0);
    clockEdge();
    applyStimulus(0, 32'h0, 1, 1, 32'h3010, 32'h1004, 0, 32'h0);
    checkOutput("starve_d_b2b_req", mem_req, 1);
    checkOutput("starve_d_b2b_addr", mem_addr, 32'h3010);
    checkOutput("starve_d_b2b_wdata", mem_wdata, 32'h1004);
    applyStimulus(0, 32'h0, 1, 1, 32'h3010, 32'h1004, 1, 32'h0);
    checkOutput("starve_d_ack", d_ack, 1);
    clockEdge();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("starve_idle_req", mem_req, 0);
    checkOutput("err_sticky", timeout_err, 1);

    // Reset during a data access drops it without an ack.
    applyStimulus(0, 32'h0, 1, 0, 32'h5000, 32'h0, 0, 32'h0);
    clockEdge();
    checkOutput("rst_busy_req", mem_req, 1);
    clockEdge();
    rst = 1'b0;
    #1;
    checkOutput("rst_no_d_ack", d_ack, 0);
    clockEdge();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_err_clear", timeout_err, 0);
    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h00000BAD);
    checkOutput("late_ack_d", d_ack, 0);
    checkOutput("late_ack_i", i_ack, 0);
    checkOutput("late_ack_rdata", d_rdata, 0);
    clockEdge();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("late_ack_idle", mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
